// File: rtl/atari_vid_pkg.sv
// Shared video definitions for the frame buffer path.
//   - Pixel field widths and the SRAM word-address width.
//   - The SRAM arbiter FSM state encoding.
//   - A helper that extracts the SRAM address {X,Y} from a packed pixel.
// A packed pixel is {X[8:0], Y[8:0], Color[7:0]}, 26 bits wide.
package atari_vid_pkg;

  localparam int PIX_X_W     = 9;
  localparam int PIX_Y_W     = 9;
  localparam int COLOR_W     = 8;
  localparam int SRAM_ADDR_W = 18;
  localparam int PIX_W       = PIX_X_W + PIX_Y_W + COLOR_W;

  typedef enum logic [1:0] {
    ST_READ  = 2'd0,
    ST_WRITE = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  function automatic logic [SRAM_ADDR_W-1:0] pix_addr(input logic [PIX_W-1:0] pix);
    return pix[PIX_W-1:COLOR_W];
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous single-clock pixel FIFO.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (pointers and level only)
//   push, din   : write strobe and payload; ignored when full
//   pop         : read strobe; ignored when empty
//   dout        : head-of-queue entry (combinational read of the array)
//   level       : current occupancy, 0..DEPTH
//   full, empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage holds no reset: stale entries are never visible past the level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/frame_sram_arbiter.sv
// Frame-buffer SRAM arbiter between NTSC pixel capture (writes) and VGA
// fetch (reads). Captured pixels queue in a FIFO and are drained into SRAM
// only while the VGA side sits in its sync window; otherwise the SRAM serves
// VGA reads with one-cycle latency. A single TURN cycle separates a write
// burst from the following reads so the data bus is released first.
// Ports:
//   iCLK, iRST                       : clock, asynchronous active-high reset
//   iPix_Valid/X/Y/Color, oPix_Ready : pixel write request and FIFO accept
//   iSync                            : VGA sync window, writes permitted
//   iRd_Addr                         : VGA fetch address
//   oSRAM_ADDR, oSRAM_DQ_OUT,
//   oSRAM_DQ_OE, oSRAM_WE_N,
//   iSRAM_DQ_IN                      : SRAM bus (all outputs registered)
//   oRd_Data, oRd_Valid              : fetched colour and its strobe
//   oLevel, oOverflow, iClr_Ovf      : FIFO occupancy, sticky drop flag, clear
module frame_sram_arbiter
  import atari_vid_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 18
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iPix_Valid,
  input  logic [8:0]             iPix_X,
  input  logic [8:0]             iPix_Y,
  input  logic [7:0]             iPix_Color,
  output logic                   oPix_Ready,
  input  logic                   iSync,
  input  logic [ADDR_W-1:0]      iRd_Addr,
  output logic [ADDR_W-1:0]      oSRAM_ADDR,
  output logic [15:0]            oSRAM_DQ_OUT,
  output logic                   oSRAM_DQ_OE,
  output logic                   oSRAM_WE_N,
  input  logic [15:0]            iSRAM_DQ_IN,
  output logic [7:0]             oRd_Data,
  output logic                   oRd_Valid,
  output logic [$clog2(DEPTH):0] oLevel,
  output logic                   oOverflow,
  input  logic                   iClr_Ovf
);

  arb_state_t       state;
  logic [PIX_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             write_go;
  logic             fetch_vld_p0;
  logic             unused_dq_hi;

  assign unused_dq_hi = ^iSRAM_DQ_IN[15:8];
  assign oPix_Ready   = ~fifo_full;

  // Issue (or continue) a write on this edge whenever sync allows and data waits.
  assign write_go = iSync & ~fifo_empty & (state != ST_TURN);

  pixel_fifo #(
    .DEPTH (DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRST),
    .push  (iPix_Valid),
    .pop   (write_go),
    .din   ({iPix_X, iPix_Y, iPix_Color}),
    .dout  (head),
    .level (oLevel),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Overflow is sticky; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                           oOverflow <= 1'b0;
    else if (iPix_Valid & fifo_full)    oOverflow <= 1'b1;
    else if (iClr_Ovf)                  oOverflow <= 1'b0;
  end

  // Stage p0: bus command issue. Outputs are registered for the state being entered.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state        <= ST_READ;
      oSRAM_ADDR   <= '0;
      oSRAM_DQ_OUT <= '0;
      oSRAM_DQ_OE  <= 1'b0;
      oSRAM_WE_N   <= 1'b1;
      fetch_vld_p0 <= 1'b0;
    end else if (write_go) begin
      state        <= ST_WRITE;
      oSRAM_ADDR   <= ADDR_W'(pix_addr(head));
      oSRAM_DQ_OUT <= {8'h00, head[COLOR_W-1:0]};
      oSRAM_DQ_OE  <= 1'b1;
      oSRAM_WE_N   <= 1'b0;
      fetch_vld_p0 <= 1'b0;
    end else begin
      // Leaving WRITE goes through TURN: the bus is released and this fetch discarded.
      state        <= (state == ST_WRITE) ? ST_TURN : ST_READ;
      oSRAM_ADDR   <= iRd_Addr;
      oSRAM_DQ_OE  <= 1'b0;
      oSRAM_WE_N   <= 1'b1;
      fetch_vld_p0 <= (state != ST_WRITE);
    end
  end

  // Stage p1: read data capture, one edge after the address was issued.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oRd_Valid <= 1'b0;
      oRd_Data  <= '0;
    end else begin
      oRd_Valid <= fetch_vld_p0;
      if (fetch_vld_p0) oRd_Data <= iSRAM_DQ_IN[7:0];
    end
  end

endmodule

// File: tb/tb_frame_sram_arbiter.sv
module tb_frame_sram_arbiter;
  import atari_vid_pkg::*;

  localparam int DEPTH = 16;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iPix_Valid;
  logic [8:0]  iPix_X;
  logic [8:0]  iPix_Y;
  logic [7:0]  iPix_Color;
  logic        oPix_Ready;
  logic        iSync;
  logic [17:0] iRd_Addr;
  logic [17:0] oSRAM_ADDR;
  logic [15:0] oSRAM_DQ_OUT;
  logic        oSRAM_DQ_OE;
  logic        oSRAM_WE_N;
  logic [15:0] iSRAM_DQ_IN;
  logic [7:0]  oRd_Data;
  logic        oRd_Valid;
  logic [4:0]  oLevel;
  logic        oOverflow;
  logic        iClr_Ovf;

  int checks = 0;
  int passed = 0;

  frame_sram_arbiter #(.DEPTH(DEPTH), .ADDR_W(18)) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iPix_Valid   (iPix_Valid),
    .iPix_X       (iPix_X),
    .iPix_Y       (iPix_Y),
    .iPix_Color   (iPix_Color),
    .oPix_Ready   (oPix_Ready),
    .iSync        (iSync),
    .iRd_Addr     (iRd_Addr),
    .oSRAM_ADDR   (oSRAM_ADDR),
    .oSRAM_DQ_OUT (oSRAM_DQ_OUT),
    .oSRAM_DQ_OE  (oSRAM_DQ_OE),
    .oSRAM_WE_N   (oSRAM_WE_N),
    .iSRAM_DQ_IN  (iSRAM_DQ_IN),
    .oRd_Data     (oRd_Data),
    .oRd_Valid    (oRd_Valid),
    .oLevel       (oLevel),
    .oOverflow    (oOverflow),
    .iClr_Ovf     (iClr_Ovf)
  );

  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle_inputs();
    iPix_Valid  = 1'b0;
    iPix_X      = '0;
    iPix_Y      = '0;
    iPix_Color  = '0;
    iSync       = 1'b0;
    iRd_Addr    = '0;
    iSRAM_DQ_IN = '0;
    iClr_Ovf    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    iRST = 1'b1;
    step();
    iRST = 1'b0;
  endtask

  function automatic logic [25:0] spix(input int k);
    logic [8:0] x;
    logic [8:0] y;
    logic [7:0] c;
    x = 9'(3 * k + 1);
    y = 9'(k + 100);
    c = 8'(7 * k + 5);
    return {x, y, c};
  endfunction

  task automatic test_reset();
    idle_inputs();
    iRST = 1'b1;
    step();
    step();
    checks++; if (oLevel !== 5'd0) $display("FAIL rst_level: got %0d want 0", oLevel); else passed++;
    checks++; if (oPix_Ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", oPix_Ready); else passed++;
    checks++; if (oOverflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", oOverflow); else passed++;
    checks++; if (oRd_Valid !== 1'b0) $display("FAIL rst_rd_valid: got %b want 0", oRd_Valid); else passed++;
    checks++; if (oRd_Data !== 8'h00) $display("FAIL rst_rd_data: got %h want 00", oRd_Data); else passed++;
    checks++; if (oSRAM_ADDR !== 18'h0) $display("FAIL rst_addr: got %h want 0", oSRAM_ADDR); else passed++;
    checks++; if (oSRAM_DQ_OUT !== 16'h0) $display("FAIL rst_dq_out: got %h want 0", oSRAM_DQ_OUT); else passed++;
    checks++; if (oSRAM_DQ_OE !== 1'b0) $display("FAIL rst_dq_oe: got %b want 0", oSRAM_DQ_OE); else passed++;
    checks++; if (oSRAM_WE_N !== 1'b1) $display("FAIL rst_we_n: got %b want 1", oSRAM_WE_N); else passed++;
    checks++; if (dut.state !== ST_READ) $display("FAIL rst_state: got %0d want %0d", dut.state, ST_READ); else passed++;
    iRST = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    iPix_Valid = 1'b1; iPix_X = 9'd5; iPix_Y = 9'd7; iPix_Color = 8'h3A;
    step();
    iPix_Valid = 1'b0;
    step();
    step();
    checks++; if (oLevel !== 5'd1) $display("FAIL sw_level_held: got %0d want 1", oLevel); else passed++;
    checks++; if (oSRAM_WE_N !== 1'b1) $display("FAIL sw_no_write_nosync: got %b want 1", oSRAM_WE_N); else passed++;
    iSync = 1'b1;
    iRd_Addr = 18'h00111;
    step();
    checks++; if (oSRAM_ADDR !== 18'h00A07) $display("FAIL sw_addr: got %h want 00a07", oSRAM_ADDR); else passed++;
    checks++; if (oSRAM_DQ_OUT !== 16'h003A) $display("FAIL sw_dq: got %h want 003a", oSRAM_DQ_OUT); else passed++;
    checks++; if (oSRAM_WE_N !== 1'b0) $display("FAIL sw_we_n: got %b want 0", oSRAM_WE_N); else passed++;
    checks++; if (oSRAM_DQ_OE !== 1'b1) $display("FAIL sw_oe: got %b want 1", oSRAM_DQ_OE); else passed++;
    checks++; if (oLevel !== 5'd0) $display("FAIL sw_level_after: got %0d want 0", oLevel); else passed++;
    step();
    checks++; if (dut.state !== ST_TURN) $display("FAIL sw_turn_state: got %0d want %0d", dut.state, ST_TURN); else passed++;
    checks++; if (oSRAM_WE_N !== 1'b1 || oSRAM_DQ_OE !== 1'b0) $display("FAIL sw_turn_bus: got we_n=%b oe=%b want we_n=1 oe=0", oSRAM_WE_N, oSRAM_DQ_OE); else passed++;
    checks++; if (oSRAM_ADDR !== 18'h00111) $display("FAIL sw_turn_addr: got %h want 00111", oSRAM_ADDR); else passed++;
    step();
    checks++; if (dut.state !== ST_READ) $display("FAIL sw_read_state: got %0d want %0d", dut.state, ST_READ); else passed++;
    checks++; if (oRd_Valid !== 1'b0) $display("FAIL sw_turn_fetch_suppressed: got %b want 0", oRd_Valid); else passed++;
    step();
    checks++; if (oRd_Valid !== 1'b1) $display("FAIL sw_read_resumes: got %b want 1", oRd_Valid); else passed++;
    iSync = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      iPix_Valid = 1'b1; iPix_X = 9'(i); iPix_Y = 9'(i); iPix_Color = 8'(i);
      step();
    end
    checks++; if (oLevel !== 5'd16) $display("FAIL ovf_full_level: got %0d want 16", oLevel); else passed++;
    checks++; if (oPix_Ready !== 1'b0) $display("FAIL ovf_ready: got %b want 0", oPix_Ready); else passed++;
    checks++; if (oOverflow !== 1'b0) $display("FAIL ovf_not_yet: got %b want 0", oOverflow); else passed++;
    step();
    checks++; if (oOverflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", oOverflow); else passed++;
    checks++; if (oLevel !== 5'd16) $display("FAIL ovf_level_capped: got %0d want 16", oLevel); else passed++;
    iClr_Ovf = 1'b1;
    step();
    checks++; if (oOverflow !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", oOverflow); else passed++;
    iPix_Valid = 1'b0;
    step();
    checks++; if (oOverflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", oOverflow); else passed++;
    iClr_Ovf = 1'b0;
  endtask

  task automatic test_burst();
    logic [17:0] ea;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      iPix_Valid = 1'b1; iPix_X = 9'(i + 1); iPix_Y = 9'(2 * i); iPix_Color = 8'(8'h10 + i);
      step();
    end
    iPix_Valid = 1'b0;
    checks++; if (oLevel !== 5'd10) $display("FAIL burst_queued: got %0d want 10", oLevel); else passed++;
    iSync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      ea = {9'(i + 1), 9'(2 * i)};
      checks++; if (oSRAM_ADDR !== ea || oSRAM_DQ_OUT !== {8'h00, 8'(8'h10 + i)} || oSRAM_WE_N !== 1'b0)
        $display("FAIL burst_write%0d: got addr=%h dq=%h we_n=%b want addr=%h dq=%h we_n=0",
                 i, oSRAM_ADDR, oSRAM_DQ_OUT, oSRAM_WE_N, ea, {8'h00, 8'(8'h10 + i)});
      else passed++;
    end
    iSync = 1'b0;
    step();
    checks++; if (oSRAM_WE_N !== 1'b1 || oSRAM_DQ_OE !== 1'b0) $display("FAIL burst_turn_bus: got we_n=%b oe=%b want 1/0", oSRAM_WE_N, oSRAM_DQ_OE); else passed++;
    checks++; if (oLevel !== 5'd6) $display("FAIL burst_level: got %0d want 6", oLevel); else passed++;
    step();
    checks++; if (oRd_Valid !== 1'b0) $display("FAIL burst_after_turn_valid: got %b want 0", oRd_Valid); else passed++;
    checks++; if (oSRAM_WE_N !== 1'b1 || oLevel !== 5'd6) $display("FAIL burst_no_extra_write: got we_n=%b level=%0d want 1/6", oSRAM_WE_N, oLevel); else passed++;
    step();
    checks++; if (oRd_Valid !== 1'b1) $display("FAIL burst_read_back: got %b want 1", oRd_Valid); else passed++;
  endtask

  task automatic test_read();
    do_reset();
    iRd_Addr = 18'h12345; iSRAM_DQ_IN = 16'hBEEF;
    step();
    checks++; if (oSRAM_ADDR !== 18'h12345 || oSRAM_WE_N !== 1'b1 || oSRAM_DQ_OE !== 1'b0)
      $display("FAIL rd_addr: got addr=%h we_n=%b oe=%b want 12345/1/0", oSRAM_ADDR, oSRAM_WE_N, oSRAM_DQ_OE);
    else passed++;
    step();
    checks++; if (oRd_Data !== 8'hEF || oRd_Valid !== 1'b1) $display("FAIL rd_data: got %h v=%b want ef v=1", oRd_Data, oRd_Valid); else passed++;
    iPix_Valid = 1'b1; iPix_X = 9'd1; iPix_Y = 9'd2; iPix_Color = 8'h77; iSRAM_DQ_IN = 16'h00AA;
    step();
    checks++; if (oRd_Data !== 8'hAA) $display("FAIL rd_data2: got %h want aa", oRd_Data); else passed++;
    iPix_Valid = 1'b0; iSync = 1'b1; iSRAM_DQ_IN = 16'h0055;
    step();
    checks++; if (oSRAM_WE_N !== 1'b0 || oRd_Data !== 8'h55) $display("FAIL rd_write_edge: got we_n=%b data=%h want 0/55", oSRAM_WE_N, oRd_Data); else passed++;
    iSync = 1'b0; iSRAM_DQ_IN = 16'h0066;
    step();
    checks++; if (oRd_Valid !== 1'b0 || oRd_Data !== 8'h55) $display("FAIL rd_hold_turn: got v=%b data=%h want 0/55", oRd_Valid, oRd_Data); else passed++;
    step();
    checks++; if (oRd_Valid !== 1'b0 || oRd_Data !== 8'h55) $display("FAIL rd_hold_after_turn: got v=%b data=%h want 0/55", oRd_Valid, oRd_Data); else passed++;
    step();
    checks++; if (oRd_Valid !== 1'b1 || oRd_Data !== 8'h66) $display("FAIL rd_resume: got v=%b data=%h want 1/66", oRd_Valid, oRd_Data); else passed++;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      iPix_Valid = 1'b1; iPix_X = 9'(i); iPix_Y = 9'(i + 50); iPix_Color = 8'(i);
      step();
    end
    iPix_Valid = 1'b0; iSync = 1'b1;
    step();
    checks++; if (oSRAM_WE_N !== 1'b0 || oLevel !== 5'd3) $display("FAIL mrst_in_write: got we_n=%b level=%0d want 0/3", oSRAM_WE_N, oLevel); else passed++;
    #2;
    iRST = 1'b1;
    #1;
    checks++; if (oSRAM_WE_N !== 1'b1 || oSRAM_DQ_OE !== 1'b0) $display("FAIL mrst_async_bus: got we_n=%b oe=%b want 1/0", oSRAM_WE_N, oSRAM_DQ_OE); else passed++;
    checks++; if (oLevel !== 5'd0 || oPix_Ready !== 1'b1) $display("FAIL mrst_flush: got level=%0d ready=%b want 0/1", oLevel, oPix_Ready); else passed++;
    iRST = 1'b0;
    step();
    checks++; if (dut.state !== ST_READ || oSRAM_WE_N !== 1'b1) $display("FAIL mrst_after: got state=%0d we_n=%b want %0d/1", dut.state, oSRAM_WE_N, ST_READ); else passed++;
    iSync = 1'b0;
  endtask

  task automatic test_stream();
    logic [25:0] p;
    logic [25:0] e;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      p = spix(k);
      iPix_Valid = 1'b1; iPix_X = p[25:17]; iPix_Y = p[16:8]; iPix_Color = p[7:0];
      step();
    end
    iSync = 1'b1;
    for (int k = 0; k < 20; k++) begin
      p = spix(k + 2);
      e = spix(k);
      iPix_Valid = 1'b1; iPix_X = p[25:17]; iPix_Y = p[16:8]; iPix_Color = p[7:0];
      step();
      checks++; if (oLevel !== 5'd2) $display("FAIL stream_level%0d: got %0d want 2", k, oLevel); else passed++;
      checks++; if (oSRAM_ADDR !== e[25:8] || oSRAM_DQ_OUT !== {8'h00, e[7:0]} || oSRAM_WE_N !== 1'b0)
        $display("FAIL stream_write%0d: got addr=%h dq=%h we_n=%b want addr=%h dq=%h we_n=0",
                 k, oSRAM_ADDR, oSRAM_DQ_OUT, oSRAM_WE_N, e[25:8], {8'h00, e[7:0]});
      else passed++;
    end
    iPix_Valid = 1'b0; iSync = 1'b0;
    step();
    checks++; if (oSRAM_WE_N !== 1'b1 || oLevel !== 5'd2) $display("FAIL stream_end: got we_n=%b level=%0d want 1/2", oSRAM_WE_N, oLevel); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_burst();
    test_read();
    test_reset_mid_write();
    test_stream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
